mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) memory arbiter issuing fixed-length bursts to an auto-incrementing memory.
// Optional macro ARB_RR_EN: round-robin tie breaking; otherwise the data port wins ties.
module mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic [1:0]  f_size,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_rd_wr,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_wnext,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_rd_wr,
    output logic        mem_enable,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_busy
);

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_4WORD = 2'd2;
    localparam logic [1:0] SZ_8WORD = 2'd3;

    // Pending-beat pattern when only the final read beat is still in flight.
    localparam logic [RD_LAT-1:0] LAST_ONLY = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              rd_wr_q, rd_wr_d;
    logic              own_d_q, own_d_d;
    logic [RD_LAT-1:0] pend_q, pend_d;
`ifdef ARB_RR_EN
    logic              pref_d_q, pref_d_d;
`endif

    logic       win_d;
    logic [2:0] last_beat;
    logic       in_burst;
    logic       rv;

    function automatic logic [2:0] last_of(input logic [1:0] sz);
        case (sz)
            SZ_BYTE:  last_of = 3'd0;
            SZ_WORD:  last_of = 3'd0;
            SZ_4WORD: last_of = 3'd3;
            SZ_8WORD: last_of = 3'd7;
            default:  last_of = 3'd0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        size_d    = size_q;
        rd_wr_d   = rd_wr_q;
        own_d_d   = own_d_q;
        last_beat = last_of(size_q);
        // Each enabled read beat enters the latency pipe; its exit is the rvalid.
        pend_d    = pend_q << 1;
        pend_d[0] = (state_q == BURST) && rd_wr_q;
`ifdef ARB_RR_EN
        pref_d_d  = pref_d_q;
        win_d     = d_req && (!f_req || pref_d_q);
`else
        win_d     = d_req;
`endif
        case (state_q)
            IDLE: begin
                if (!mem_busy && (f_req || d_req)) begin
                    state_d = BURST;
                    beat_d  = 3'd0;
                    own_d_d = win_d;
                    addr_d  = win_d ? d_addr : f_addr;
                    size_d  = win_d ? d_size : f_size;
                    rd_wr_d = win_d ? d_rd_wr : 1'b1;
`ifdef ARB_RR_EN
                    pref_d_d = !win_d;
`endif
                end
            end
            BURST: begin
                if (beat_q == last_beat) begin
                    beat_d  = 3'd0;
                    state_d = rd_wr_q ? DRAIN : IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            DRAIN: begin
                if (pend_q == LAST_ONLY || pend_q == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 3'd0;
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            rd_wr_q  <= 1'b1;
            own_d_q  <= 1'b1;
            pend_q   <= '0;
`ifdef ARB_RR_EN
            pref_d_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            rd_wr_q  <= rd_wr_d;
            own_d_q  <= own_d_d;
            pend_q   <= pend_d;
`ifdef ARB_RR_EN
            pref_d_q <= pref_d_d;
`endif
        end
    end

    assign in_burst   = (state_q == BURST);
    assign rv         = pend_q[RD_LAT-1];

    assign mem_enable = in_burst;
    assign mem_addr   = addr_q;
    assign mem_size   = size_q;
    assign mem_rd_wr  = rd_wr_q;
    assign mem_din    = (in_burst && !rd_wr_q) ? d_wdata : 32'd0;

    assign d_wnext    = in_burst && !rd_wr_q;
    assign d_gnt      = in_burst && (beat_q == 3'd0) && own_d_q;
    assign f_gnt      = in_burst && (beat_q == 3'd0) && !own_d_q;

    assign d_rvalid   = rv && own_d_q;
    assign f_rvalid   = rv && !own_d_q;
    assign d_rdata    = d_rvalid ? mem_dout : 32'd0;
    assign f_rdata    = f_rvalid ? mem_dout : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at read latency 1, one at latency 3, sharing stimulus.
module tb_mem_arbiter;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_4WORD = 2'd2;
    localparam logic [1:0] SZ_8WORD = 2'd3;

    logic        clk, rst;
    logic        f_req, d_req, d_rd_wr, mem_busy;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [1:0]  f_size, d_size;

    logic        a_f_gnt, a_f_rvalid, a_d_gnt, a_d_wnext, a_d_rvalid, a_mem_rd_wr, a_mem_enable;
    logic [31:0] a_f_rdata, a_d_rdata, a_mem_addr, a_mem_din, a_mem_dout;
    logic [1:0]  a_mem_size;
    logic        b_f_gnt, b_f_rvalid, b_d_gnt, b_d_wnext, b_d_rvalid, b_mem_rd_wr, b_mem_enable;
    logic [31:0] b_f_rdata, b_d_rdata, b_mem_addr, b_mem_din, b_mem_dout;
    logic [1:0]  b_mem_size;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] wq[$];
    logic [31:0] wwords [8] = '{32'hAAAAAAAA, 32'h99999999, 32'h88888888, 32'h77777777,
                                32'h66666666, 32'h44444444, 32'h22222222, 32'h11111111};

    mem_arbiter #(.RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_size(f_size),
        .f_gnt(a_f_gnt), .f_rvalid(a_f_rvalid), .f_rdata(a_f_rdata),
        .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_wnext(a_d_wnext), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_size(a_mem_size), .mem_rd_wr(a_mem_rd_wr),
        .mem_enable(a_mem_enable), .mem_din(a_mem_din),
        .mem_dout(a_mem_dout), .mem_busy(mem_busy)
    );

    mem_arbiter #(.RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_size(f_size),
        .f_gnt(b_f_gnt), .f_rvalid(b_f_rvalid), .f_rdata(b_f_rdata),
        .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_wnext(b_d_wnext), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_size(b_mem_size), .mem_rd_wr(b_mem_rd_wr),
        .mem_enable(b_mem_enable), .mem_din(b_mem_din),
        .mem_dout(b_mem_dout), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: word at byte address X reads as ~X; idle slots carry a marker value.
    logic [3:0][31:0] a_dl, b_dl;
    int a_cnt = 0, b_cnt = 0;
    always @(posedge clk) begin
        a_cnt <= a_mem_enable ? a_cnt + 1 : 0;
        b_cnt <= b_mem_enable ? b_cnt + 1 : 0;
        a_dl  <= {a_dl[2:0], (a_mem_enable && a_mem_rd_wr) ? ~(a_mem_addr + 32'(a_cnt) * 4) : 32'hDEADBEEF};
        b_dl  <= {b_dl[2:0], (b_mem_enable && b_mem_rd_wr) ? ~(b_mem_addr + 32'(b_cnt) * 4) : 32'hDEADBEEF};
    end
    assign a_mem_dout = a_dl[0];
    assign b_mem_dout = b_dl[2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, inout logic [31:0] q[$], input logic [31:0] obs);
        if (q.size() == 0) chk({tag, "_underflow"}, obs, 32'hxxxxxxxx);
        else chk(tag, obs, q.pop_front());
    endtask

    task automatic req_d(input bit rd, input logic [31:0] addr, input logic [1:0] sz, input int nb);
        d_req = 1'b1; d_rd_wr = rd; d_addr = addr; d_size = sz;
        for (int i = 0; i < nb; i++) begin
            if (rd) begin
                qa.push_back(~(addr + 32'(i) * 4));
                qb.push_back(~(addr + 32'(i) * 4));
            end else begin
                wq.push_back(wwords[i]);
            end
        end
        d_wdata = wwords[0];
    endtask

    task automatic req_f(input logic [31:0] addr, input logic [1:0] sz, input int nb);
        f_req = 1'b1; f_addr = addr; f_size = sz;
        for (int i = 0; i < nb; i++) begin
            qa.push_back(~(addr + 32'(i) * 4));
            qb.push_back(~(addr + 32'(i) * 4));
        end
    endtask

    // Entered in the grant cycle (c=0); walks the transfer cycle by cycle.
    task automatic mon(input int ncyc, input int nb, input bit rd, input bit own_d,
                       input logic [31:0] addr, input logic [1:0] sz);
        int  wi = 0;
        bit  prev_wn = 1'b0;
        bit  ea, eb;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                if (prev_wn && wi < 7) begin
                    wi++;
                    d_wdata = wwords[wi];
                end
                #1;
            end
            chk("en_a", a_mem_enable, 32'(c < nb));
            chk("en_b", b_mem_enable, 32'(c < nb));
            chk("dgnt", a_d_gnt, 32'(c == 0 && own_d));
            chk("fgnt", a_f_gnt, 32'(c == 0 && !own_d));
            if (c < nb) begin
                chk("addr", a_mem_addr, addr);
                chk("size", a_mem_size, sz);
                chk("rdwr", a_mem_rd_wr, rd);
            end
            chk("wnext", a_d_wnext, 32'(!rd && c < nb));
            if (!rd && c < nb) pop_chk("din", wq, a_mem_din);
            ea = rd && c >= 1 && c <= nb;
            eb = rd && c >= 3 && c <= nb + 2;
            chk("rv_own_a", own_d ? a_d_rvalid : a_f_rvalid, 32'(ea));
            chk("rv_oth_a", own_d ? a_f_rvalid : a_d_rvalid, 32'd0);
            chk("rv_own_b", own_d ? b_d_rvalid : b_f_rvalid, 32'(eb));
            chk("rv_oth_b", own_d ? b_f_rvalid : b_d_rvalid, 32'd0);
            if (own_d ? a_d_rvalid : a_f_rvalid) pop_chk("rdata_a", qa, own_d ? a_d_rdata : a_f_rdata);
            else chk("rdata0_a", own_d ? a_d_rdata : a_f_rdata, 32'd0);
            if (own_d ? b_d_rvalid : b_f_rvalid) pop_chk("rdata_b", qb, own_d ? b_d_rdata : b_f_rdata);
            else chk("rdata0_b", own_d ? b_d_rdata : b_f_rdata, 32'd0);
            prev_wn = a_d_wnext;
            if (c == 0) begin
                d_req = 1'b0;
                f_req = 1'b0;
            end
        end
    endtask

    task automatic chk_rst();
        chk("rst_fgnt", a_f_gnt, 32'd0);
        chk("rst_dgnt", a_d_gnt, 32'd0);
        chk("rst_frv", a_f_rvalid, 32'd0);
        chk("rst_drv", a_d_rvalid, 32'd0);
        chk("rst_wnext", a_d_wnext, 32'd0);
        chk("rst_en", a_mem_enable, 32'd0);
        chk("rst_addr", a_mem_addr, 32'd0);
        chk("rst_din", a_mem_din, 32'd0);
        chk("rst_size", a_mem_size, 32'd0);
        chk("rst_rdwr", a_mem_rd_wr, 32'd1);
        chk("rst_en_b", b_mem_enable, 32'd0);
        chk("rst_frv_b", b_f_rvalid, 32'd0);
        chk("rst_drv_b", b_d_rvalid, 32'd0);
    endtask

    initial begin
        logic [3:0] ga, gb, gexp;
        int         na, nb_;
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_rd_wr = 1'b1; mem_busy = 1'b0;
        f_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; f_size = 2'd0; d_size = 2'd0;
        tick(); tick();
        chk_rst();
        rst = 1'b0;
        tick();

        // 4-word data read
        req_d(1'b1, 32'h80020000, SZ_4WORD, 4);
        tick();
        mon(8, 4, 1'b1, 1'b1, 32'h80020000, SZ_4WORD);
        tick();

        // 8-word data write
        req_d(1'b0, 32'h80021000, SZ_8WORD, 8);
        tick();
        mon(10, 8, 1'b0, 1'b1, 32'h80021000, SZ_8WORD);
        tick();

        // byte write, then regrant after a single idle cycle
        req_d(1'b0, 32'h80020003, SZ_BYTE, 1);
        tick();
        mon(2, 1, 1'b0, 1'b1, 32'h80020003, SZ_BYTE);
        req_d(1'b1, 32'h80020004, SZ_WORD, 1);
        tick();
        mon(6, 1, 1'b1, 1'b1, 32'h80020004, SZ_WORD);
        tick();

        // memory busy holds off the fetch grant
        mem_busy = 1'b1;
        req_f(32'h80030000, SZ_WORD, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_fgnt_a", a_f_gnt, 32'd0);
            chk("busy_fgnt_b", b_f_gnt, 32'd0);
            chk("busy_en", a_mem_enable, 32'd0);
        end
        mem_busy = 1'b0;
        tick();
        mon(6, 1, 1'b1, 1'b0, 32'h80030000, SZ_WORD);
        tick();

        // both ports requesting continuously
        f_req = 1'b1; f_addr = 32'h00001000; f_size = SZ_WORD;
        d_req = 1'b1; d_rd_wr = 1'b1; d_addr = 32'h00002000; d_size = SZ_WORD;
        ga = 4'd0; gb = 4'd0; na = 0; nb_ = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if ((a_d_gnt || a_f_gnt) && na < 4) begin
                ga[na] = a_d_gnt;
                chk("tie_addr", a_mem_addr, a_d_gnt ? 32'h00002000 : 32'h00001000);
                na++;
            end
            if ((b_d_gnt || b_f_gnt) && nb_ < 4) begin
                gb[nb_] = b_d_gnt;
                nb_++;
            end
        end
`ifdef ARB_RR_EN
        gexp = 4'b0101;
`else
        gexp = 4'b1111;
`endif
        chk("tie_cnt_a", na, 4);
        chk("tie_seq_a", ga, gexp);
        chk("tie_seq_b", gb, gexp);
        f_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // reset during beat 3 of an 8-word fetch read
        f_req = 1'b1; f_addr = 32'h80040000; f_size = SZ_8WORD;
        tick();
        chk("r8_fgnt", a_f_gnt, 32'd1);
        f_req = 1'b0;
        tick();
        chk("r8_rv1", a_f_rvalid, 32'd1);
        chk("r8_rd1", a_f_rdata, ~32'h80040000);
        tick();
        chk("r8_en3", a_mem_enable, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_rst();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_frv_a", a_f_rvalid, 32'd0);
            chk("post_rst_frv_b", b_f_rvalid, 32'd0);
            chk("post_rst_drv_b", b_d_rvalid, 32'd0);
            chk("post_rst_en", a_mem_enable, 32'd0);
        end
        chk("sb_empty", 32'(qa.size() + qb.size() + wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
